// File: rtl/axi_res_pkg.sv
// Shared types and helpers for the associative LR/SC reservation table.
// Entry field widths follow the default bus configuration below.
package axi_res_pkg;

  localparam int unsigned RES_ADDR_W       = 64;
  localparam int unsigned RES_ID_W         = 4;
  localparam int unsigned RES_GRANULE_BITS = 3;
  localparam int unsigned RES_TAG_W        = RES_ADDR_W - RES_GRANULE_BITS;
  // Age field is sized for the longest supported lifetime (TIMEOUT_CYCLES <= 65535).
  localparam int unsigned RES_AGE_W        = 16;

  typedef struct packed {
    logic                 valid;
    logic [RES_ID_W-1:0]  id;
    logic [RES_TAG_W-1:0] tag;
    logic [RES_AGE_W-1:0] age;
  } res_entry_t;

  function automatic logic [RES_TAG_W-1:0] granule_of(input logic [RES_ADDR_W-1:0] addr);
    return addr[RES_ADDR_W-1:RES_GRANULE_BITS];
  endfunction

endpackage

// File: rtl/axi_res_tbl_assoc_if.sv
// Request/grant bundle between the LR/SC/AMO decoder and the reservation table.
interface axi_res_tbl_assoc_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned N_ENTRIES      = 4
);
  localparam int unsigned OCC_W = $clog2(N_ENTRIES + 1);

  logic [AXI_ADDR_WIDTH-1:0] clr_addr_i;
  logic                      clr_req_i;
  logic                      clr_gnt_o;
  logic [AXI_ADDR_WIDTH-1:0] set_addr_i;
  logic [AXI_ID_WIDTH-1:0]   set_id_i;
  logic                      set_req_i;
  logic                      set_gnt_o;
  logic [AXI_ADDR_WIDTH-1:0] check_addr_i;
  logic [AXI_ID_WIDTH-1:0]   check_id_i;
  logic                      check_req_i;
  logic                      check_gnt_o;
  logic                      check_res_o;
  logic                      evict_o;
  logic [OCC_W-1:0]          occupancy_o;

  modport slave (
    input  clr_addr_i, clr_req_i, set_addr_i, set_id_i, set_req_i,
           check_addr_i, check_id_i, check_req_i,
    output clr_gnt_o, set_gnt_o, check_gnt_o, check_res_o, evict_o, occupancy_o
  );

  modport master (
    output clr_addr_i, clr_req_i, set_addr_i, set_id_i, set_req_i,
           check_addr_i, check_id_i, check_req_i,
    input  clr_gnt_o, set_gnt_o, check_gnt_o, check_res_o, evict_o, occupancy_o
  );

endinterface

// File: rtl/axi_res_slot_sel.sv
// Picks the slot an LR writes: same-ID entry, else lowest free, else round-robin victim.
module axi_res_slot_sel #(
  parameter int unsigned N_ENTRIES = 4,
  parameter int unsigned PTR_W     = 2
) (
  input  logic [N_ENTRIES-1:0] valid_i,
  input  logic [N_ENTRIES-1:0] id_match_i,
  input  logic [PTR_W-1:0]     rr_ptr_i,
  output logic [N_ENTRIES-1:0] slot_o,
  output logic                 evict_o
);

  always_comb begin
    slot_o  = '0;
    evict_o = 1'b0;
    // x & -x isolates the lowest set bit, giving a one-hot slot directly.
    if (|id_match_i) begin
      slot_o = id_match_i & (~id_match_i + N_ENTRIES'(1));
    end else if (!(&valid_i)) begin
      slot_o = ~valid_i & (valid_i + N_ENTRIES'(1));
    end else begin
      slot_o  = N_ENTRIES'(1) << rr_ptr_i;
      evict_o = 1'b1;
    end
  end

endmodule

// File: rtl/axi_res_tbl_assoc.sv
// Associative LR/SC reservation table: ID+granule tagged slots, RR eviction,
// optional expiry, and SC that always consumes the caller's reservation.
module axi_res_tbl_assoc
  import axi_res_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = RES_ADDR_W,
  parameter int unsigned AXI_ID_WIDTH   = RES_ID_W,
  parameter int unsigned N_ENTRIES      = 4,
  parameter int unsigned GRANULE_BITS   = RES_GRANULE_BITS,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  axi_res_tbl_assoc_if.slave bus
);

  localparam int unsigned TAG_W = AXI_ADDR_WIDTH - GRANULE_BITS;
  localparam int unsigned OCC_W = $clog2(N_ENTRIES + 1);
  localparam int unsigned PTR_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

  res_entry_t           ent_q [N_ENTRIES];
  res_entry_t           ent_d [N_ENTRIES];
  logic [PTR_W-1:0]     rr_q, rr_d;
  logic                 evict_q, evict_d;
  logic [OCC_W-1:0]     occ_q, occ_d;

  logic                 clr_gnt, set_gnt, check_gnt;
  logic [TAG_W-1:0]     clr_tag, set_tag, check_tag;
  logic [N_ENTRIES-1:0] valid_vec, set_id_hit, check_id_hit, check_hit, clr_hit;
  logic [N_ENTRIES-1:0] set_slot;
  logic                 set_evict;

  assign clr_gnt   = bus.clr_req_i;
  assign set_gnt   = bus.set_req_i & ~bus.clr_req_i;
  assign check_gnt = bus.check_req_i & ~bus.clr_req_i & ~bus.set_req_i;

  assign clr_tag   = granule_of(bus.clr_addr_i);
  assign set_tag   = granule_of(bus.set_addr_i);
  assign check_tag = granule_of(bus.check_addr_i);

  always_comb begin
    valid_vec    = '0;
    set_id_hit   = '0;
    check_id_hit = '0;
    check_hit    = '0;
    clr_hit      = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      valid_vec[i]    = ent_q[i].valid;
      set_id_hit[i]   = ent_q[i].valid && (ent_q[i].id == bus.set_id_i);
      check_id_hit[i] = ent_q[i].valid && (ent_q[i].id == bus.check_id_i);
      check_hit[i]    = check_id_hit[i] && (ent_q[i].tag == check_tag);
      clr_hit[i]      = ent_q[i].valid && (ent_q[i].tag == clr_tag);
    end
  end

  axi_res_slot_sel #(
    .N_ENTRIES (N_ENTRIES),
    .PTR_W     (PTR_W)
  ) u_slot_sel (
    .valid_i    (valid_vec),
    .id_match_i (set_id_hit),
    .rr_ptr_i   (rr_q),
    .slot_o     (set_slot),
    .evict_o    (set_evict)
  );

  assign bus.clr_gnt_o   = clr_gnt;
  assign bus.set_gnt_o   = set_gnt;
  assign bus.check_gnt_o = check_gnt;
  assign bus.check_res_o = check_gnt & (|check_hit);
  assign bus.evict_o     = evict_q;
  assign bus.occupancy_o = occ_q;

  // Expiry is applied first so a same-cycle set overwrite revives the slot with age 0.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      if (TIMEOUT_CYCLES != 0 && ent_q[i].valid) begin
        if (ent_q[i].age == RES_AGE_W'(TIMEOUT_CYCLES - 1)) begin
          ent_d[i].valid = 1'b0;
        end else begin
          ent_d[i].age = ent_q[i].age + RES_AGE_W'(1);
        end
      end
      if (clr_gnt && clr_hit[i]) begin
        ent_d[i].valid = 1'b0;
      end
      if (check_gnt && check_id_hit[i]) begin
        ent_d[i].valid = 1'b0;
      end
      if (set_gnt && set_slot[i]) begin
        ent_d[i].valid = 1'b1;
        ent_d[i].id    = bus.set_id_i;
        ent_d[i].tag   = set_tag;
        ent_d[i].age   = '0;
      end
      occ_d = occ_d + OCC_W'(ent_d[i].valid);
    end
  end

  always_comb begin
    rr_d    = rr_q;
    evict_d = set_gnt & set_evict;
    if (evict_d) begin
      rr_d = (rr_q == PTR_W'(N_ENTRIES - 1)) ? '0 : rr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        ent_q[i] <= '0;
      end
      rr_q    <= '0;
      evict_q <= 1'b0;
      occ_q   <= '0;
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        ent_q[i] <= ent_d[i];
      end
      rr_q    <= rr_d;
      evict_q <= evict_d;
      occ_q   <= occ_d;
    end
  end

endmodule

// File: tb/tb_axi_res_tbl_assoc.sv
// Directed vector table plus randomized traffic against a lifetime-based
// reservation model for the associative LR/SC table (4 slots, 8-cycle lifetime).
module tb_axi_res_tbl_assoc;

  localparam int NE = 4;
  localparam int TO = 8;

  typedef struct {
    bit          clr;
    logic [63:0] clrAddr;
    bit          set;
    logic [3:0]  setId;
    logic [63:0] setAddr;
    bit          chk;
    logic [3:0]  chkId;
    logic [63:0] chkAddr;
    bit          eClrG;
    bit          eSetG;
    bit          eChkG;
    bit          eRes;
    bit          eEvict;
    int          eOcc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testsRun = 0;
  int   testsFailed = 0;
  vec_t vecs[$];

  // Reference model: each reservation lives until its expiry cycle unless killed.
  int              mCyc;
  bit              mValid [NE];
  int              mId    [NE];
  longint unsigned mGran  [NE];
  int              mExp   [NE];
  int              mRr;
  bit              mEvict;

  always #5 clk = ~clk;

  axi_res_tbl_assoc_if #(.AXI_ADDR_WIDTH(64), .AXI_ID_WIDTH(4), .N_ENTRIES(NE)) bus ();

  axi_res_tbl_assoc #(
    .AXI_ADDR_WIDTH (64),
    .AXI_ID_WIDTH   (4),
    .N_ENTRIES      (NE),
    .GRANULE_BITS   (3),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkRow(bit clr, logic [63:0] ca, bit set, int sid, logic [63:0] sa,
                                 bit chk, int kid, logic [63:0] ka,
                                 bit eC, bit eS, bit eK, bit eR, bit eE, int eO);
    vec_t v;
    v.clr = clr;  v.clrAddr = ca;
    v.set = set;  v.setId = 4'(sid);  v.setAddr = sa;
    v.chk = chk;  v.chkId = 4'(kid);  v.chkAddr = ka;
    v.eClrG = eC; v.eSetG = eS; v.eChkG = eK; v.eRes = eR; v.eEvict = eE; v.eOcc = eO;
    return v;
  endfunction

  function automatic vec_t setRow(int id, logic [63:0] a, bit ev, int occ);
    return mkRow(0, 0, 1, id, a, 0, 0, 0, 0, 1, 0, 0, ev, occ);
  endfunction

  function automatic vec_t chkRow(int id, logic [63:0] a, bit res, bit ev, int occ);
    return mkRow(0, 0, 0, 0, 0, 1, id, a, 0, 0, 1, res, ev, occ);
  endfunction

  function automatic vec_t clrRow(logic [63:0] a, bit ev, int occ);
    return mkRow(1, a, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, ev, occ);
  endfunction

  function automatic vec_t idleRow(bit ev, int occ);
    return mkRow(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev, occ);
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.clr_req_i    = v.clr;
    bus.clr_addr_i   = v.clrAddr;
    bus.set_req_i    = v.set;
    bus.set_id_i     = v.setId;
    bus.set_addr_i   = v.setAddr;
    bus.check_req_i  = v.chk;
    bus.check_id_i   = v.chkId;
    bus.check_addr_i = v.chkAddr;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    checkVal({tag, " clr_gnt"}, bus.clr_gnt_o, v.eClrG);
    checkVal({tag, " set_gnt"}, bus.set_gnt_o, v.eSetG);
    checkVal({tag, " check_gnt"}, bus.check_gnt_o, v.eChkG);
    if (v.eChkG) checkVal({tag, " check_res"}, bus.check_res_o, v.eRes);
    checkVal({tag, " evict"}, bus.evict_o, v.eEvict);
    checkVal({tag, " occupancy"}, bus.occupancy_o, v.eOcc);
  endtask

  task automatic runRow(input string tag, input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput(tag, v);
    @(posedge clk);
    #1;
  endtask

  function automatic bit alive(int i);
    return mValid[i] && (mCyc <= mExp[i]);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NE; i++) begin
      mValid[i] = 0; mId[i] = 0; mGran[i] = 0; mExp[i] = 0;
    end
    mRr = 0; mEvict = 0; mCyc = 0;
  endtask

  // One random cycle: predict from the model, compare, then advance the model.
  task automatic randomStep(input int n);
    vec_t v;
    int   occ, slot;
    bit   hit;
    logic [63:0] a [3];
    for (int k = 0; k < 3; k++) begin
      a[k] = 64'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a[k][40] = 1'b1;
    end
    v = mkRow($urandom_range(0, 9) < 2, a[0], $urandom_range(0, 9) < 4, $urandom_range(0, 7), a[1],
              $urandom_range(0, 9) < 4, $urandom_range(0, 7), a[2], 0, 0, 0, 0, 0, 0);
    v.eClrG = v.clr;
    v.eSetG = v.set && !v.clr;
    v.eChkG = v.chk && !v.clr && !v.set;
    hit = 0;
    occ = 0;
    for (int i = 0; i < NE; i++) begin
      if (alive(i)) occ++;
      if (alive(i) && mId[i] == int'(v.chkId) && mGran[i] == (v.chkAddr >> 3)) hit = 1;
    end
    v.eRes = hit;
    v.eEvict = mEvict;
    v.eOcc = occ;
    runRow($sformatf("rand%0d", n), v);

    mEvict = 0;
    if (v.eClrG) begin
      for (int i = 0; i < NE; i++)
        if (alive(i) && mGran[i] == (v.clrAddr >> 3)) mValid[i] = 0;
    end else if (v.eSetG) begin
      slot = -1;
      for (int i = 0; i < NE; i++)
        if (slot < 0 && alive(i) && mId[i] == int'(v.setId)) slot = i;
      for (int i = 0; i < NE; i++)
        if (slot < 0 && !alive(i)) slot = i;
      if (slot < 0) begin
        slot = mRr;
        mRr = (mRr + 1) % NE;
        mEvict = 1;
      end
      mValid[slot] = 1;
      mId[slot] = int'(v.setId);
      mGran[slot] = v.setAddr >> 3;
      mExp[slot] = mCyc + TO;
    end else if (v.eChkG) begin
      for (int i = 0; i < NE; i++)
        if (alive(i) && mId[i] == int'(v.chkId)) mValid[i] = 0;
    end
    mCyc++;
  endtask

  initial begin
    applyStimulus(idleRow(0, 0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset", idleRow(0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Consume, clear, eviction, priority, final-cycle and timeout vectors.
    vecs.push_back(setRow(2, 64'h1000, 0, 0));
    vecs.push_back(chkRow(2, 64'h1004, 1, 0, 1));
    vecs.push_back(chkRow(2, 64'h1004, 0, 0, 0));
    vecs.push_back(setRow(1, 64'h2000, 0, 0));
    vecs.push_back(setRow(3, 64'h2000, 0, 1));
    vecs.push_back(clrRow(64'h2007, 0, 2));
    vecs.push_back(chkRow(1, 64'h2000, 0, 0, 0));
    vecs.push_back(setRow(0, 64'h0, 0, 0));
    vecs.push_back(setRow(1, 64'h8, 0, 1));
    vecs.push_back(setRow(2, 64'h10, 0, 2));
    vecs.push_back(setRow(3, 64'h18, 0, 3));
    vecs.push_back(setRow(5, 64'h3000, 0, 4));
    vecs.push_back(idleRow(1, 4));
    vecs.push_back(chkRow(0, 64'h0, 0, 0, 4));
    vecs.push_back(chkRow(5, 64'h3000, 1, 0, 4));
    vecs.push_back(mkRow(1, 64'h9000, 1, 6, 64'h500, 1, 2, 64'h10, 1, 0, 0, 0, 0, 3));
    vecs.push_back(mkRow(0, 0, 1, 6, 64'h500, 1, 2, 64'h10, 0, 1, 0, 0, 0, 3));
    vecs.push_back(chkRow(2, 64'h10, 1, 0, 3));
    vecs.push_back(idleRow(0, 2));
    vecs.push_back(setRow(4, 64'h40, 0, 1));
    vecs.push_back(setRow(7, 64'h40, 0, 2));
    for (int k = 0; k < 6; k++) vecs.push_back(idleRow(0, (k < 4) ? 3 : 2));
    vecs.push_back(chkRow(4, 64'h40, 1, 0, 2));
    vecs.push_back(idleRow(0, 1));
    vecs.push_back(idleRow(0, 0));
    vecs.push_back(setRow(2, 64'h100, 0, 0));
    vecs.push_back(setRow(2, 64'h200, 0, 1));
    vecs.push_back(idleRow(0, 1));
    vecs.push_back(chkRow(2, 64'h100, 0, 0, 1));
    vecs.push_back(idleRow(0, 0));
    foreach (vecs[i]) runRow($sformatf("vec%0d", i), vecs[i]);

    // Reset asserted alongside a granted set: the set must not survive.
    runRow("midrst_a", setRow(1, 64'h8, 0, 0));
    rst = 1'b1;
    runRow("midrst_b", setRow(2, 64'h10, 0, 1));
    rst = 1'b0;
    runRow("midrst_c", chkRow(2, 64'h10, 0, 0, 0));
    runRow("midrst_d", idleRow(0, 0));

    rst = 1'b1;
    applyStimulus(idleRow(0, 0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    for (int n = 0; n < 400; n++) randomStep(n);

    applyStimulus(idleRow(0, 0));
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
